// File: rtl/ll_head_pop.sv
// ll_head_pop: pops the head node of a linked list.
// It reads the head node (payload and next pointer) from node memory, returns the
// payload to the requester, drives the head-pointer update interface, and hands
// the freed node back to the free-list manager.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a request; cur_hd_ptr is latched on accept
// RD    | one-cycle node-memory read strobe at the latched head
// WAIT  | waits for the memory read latency, then captures data/next pointer
// UPD   | one-cycle head update (or list-empty) pulse and free pulse
// RESP  | response held until the requester takes it
module ll_head_pop #(
    parameter int PTR_WD     = 4,
    parameter int DATA_WD    = 8,
    parameter int MEM_RD_LAT = 1,
    parameter int CNT_WD     = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pop_req_vld,
    output logic               pop_req_rdy,
    output logic               pop_rsp_vld,
    input  logic               pop_rsp_rdy,
    output logic [DATA_WD-1:0] pop_rsp_data,
    output logic               pop_rsp_empty,
    input  logic [PTR_WD-1:0]  cur_hd_ptr,
    output logic               mem_rd_en,
    output logic [PTR_WD-1:0]  mem_rd_addr,
    input  logic [DATA_WD-1:0] mem_rd_data,
    input  logic [PTR_WD-1:0]  mem_rd_nxt_ptr,
    output logic               upd_hd_ptr,
    output logic               make_ll_empty,
    output logic [PTR_WD-1:0]  new_hd_ptr,
    output logic               free_ptr_vld,
    output logic [PTR_WD-1:0]  free_ptr,
    output logic [CNT_WD-1:0]  pop_cnt
);

    localparam logic [PTR_WD-1:0] NULL_PTR = '1;
    // Latency is limited to 1..4, so the wait counter needs only two bits.
    localparam logic [1:0]        LAT_M1   = 2'(MEM_RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        UPD,
        RESP
    } state_t;

    state_t              state;
    logic [PTR_WD-1:0]   hd_q;
    logic [DATA_WD-1:0]  data_q;
    logic [1:0]          wait_cnt;

    // Pop sequencer with all outputs registered; pulse outputs default low each cycle.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state         <= IDLE;
            hd_q          <= NULL_PTR;
            data_q        <= '0;
            wait_cnt      <= '0;
            pop_req_rdy   <= 1'b0;
            pop_rsp_vld   <= 1'b0;
            pop_rsp_data  <= '0;
            pop_rsp_empty <= 1'b0;
            mem_rd_en     <= 1'b0;
            mem_rd_addr   <= NULL_PTR;
            upd_hd_ptr    <= 1'b0;
            make_ll_empty <= 1'b0;
            new_hd_ptr    <= NULL_PTR;
            free_ptr_vld  <= 1'b0;
            free_ptr      <= NULL_PTR;
            pop_cnt       <= '0;
        end else begin
            mem_rd_en     <= 1'b0;
            upd_hd_ptr    <= 1'b0;
            make_ll_empty <= 1'b0;
            free_ptr_vld  <= 1'b0;
            case (state)
                IDLE: begin
                    pop_req_rdy <= 1'b1;
                    if (pop_req_vld && pop_req_rdy) begin
                        pop_req_rdy <= 1'b0;
                        hd_q        <= cur_hd_ptr;
                        if (cur_hd_ptr == NULL_PTR) begin
                            // Empty list: answer directly, no memory traffic.
                            state         <= RESP;
                            pop_rsp_vld   <= 1'b1;
                            pop_rsp_empty <= 1'b1;
                            pop_rsp_data  <= '0;
                        end else begin
                            state       <= RD;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= cur_hd_ptr;
                        end
                    end
                end
                RD: begin
                    state    <= WAIT;
                    wait_cnt <= LAT_M1;
                end
                WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state        <= UPD;
                        data_q       <= mem_rd_data;
                        new_hd_ptr   <= mem_rd_nxt_ptr;
                        free_ptr_vld <= 1'b1;
                        free_ptr     <= hd_q;
                        if (mem_rd_nxt_ptr == NULL_PTR) begin
                            make_ll_empty <= 1'b1;
                        end else begin
                            upd_hd_ptr <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                UPD: begin
                    state         <= RESP;
                    pop_cnt       <= pop_cnt + 1'b1;
                    pop_rsp_vld   <= 1'b1;
                    pop_rsp_empty <= 1'b0;
                    pop_rsp_data  <= data_q;
                end
                RESP: begin
                    if (pop_rsp_rdy) begin
                        state         <= IDLE;
                        pop_req_rdy   <= 1'b1;
                        pop_rsp_vld   <= 1'b0;
                        pop_rsp_empty <= 1'b0;
                        pop_rsp_data  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ll_head_pop.sv
// Testbench for ll_head_pop: one instance with 1-cycle memory latency (a_*) and one
// with 3-cycle latency (b_*), each with its own node-memory read pipeline model.
module tb_ll_head_pop;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       a_req_vld, a_req_rdy, a_rsp_vld, a_rsp_rdy, a_rsp_empty;
    logic [7:0] a_rsp_data, a_rd_data;
    logic [3:0] a_cur_hd, a_rd_addr, a_rd_nxt, a_new_hd, a_free_ptr;
    logic       a_rd_en, a_upd, a_mk, a_free_vld;
    logic [15:0] a_cnt;

    logic       b_req_vld, b_req_rdy, b_rsp_vld, b_rsp_rdy, b_rsp_empty;
    logic [7:0] b_rsp_data, b_rd_data;
    logic [3:0] b_cur_hd, b_rd_addr, b_rd_nxt, b_new_hd, b_free_ptr;
    logic       b_rd_en, b_upd, b_mk, b_free_vld;
    logic [15:0] b_cnt;

    ll_head_pop #(.PTR_WD(4), .DATA_WD(8), .MEM_RD_LAT(1), .CNT_WD(16)) dut_a (
        .clk(clk), .reset_n(rst),
        .pop_req_vld(a_req_vld), .pop_req_rdy(a_req_rdy),
        .pop_rsp_vld(a_rsp_vld), .pop_rsp_rdy(a_rsp_rdy),
        .pop_rsp_data(a_rsp_data), .pop_rsp_empty(a_rsp_empty),
        .cur_hd_ptr(a_cur_hd),
        .mem_rd_en(a_rd_en), .mem_rd_addr(a_rd_addr),
        .mem_rd_data(a_rd_data), .mem_rd_nxt_ptr(a_rd_nxt),
        .upd_hd_ptr(a_upd), .make_ll_empty(a_mk), .new_hd_ptr(a_new_hd),
        .free_ptr_vld(a_free_vld), .free_ptr(a_free_ptr),
        .pop_cnt(a_cnt)
    );

    ll_head_pop #(.PTR_WD(4), .DATA_WD(8), .MEM_RD_LAT(3), .CNT_WD(16)) dut_b (
        .clk(clk), .reset_n(rst),
        .pop_req_vld(b_req_vld), .pop_req_rdy(b_req_rdy),
        .pop_rsp_vld(b_rsp_vld), .pop_rsp_rdy(b_rsp_rdy),
        .pop_rsp_data(b_rsp_data), .pop_rsp_empty(b_rsp_empty),
        .cur_hd_ptr(b_cur_hd),
        .mem_rd_en(b_rd_en), .mem_rd_addr(b_rd_addr),
        .mem_rd_data(b_rd_data), .mem_rd_nxt_ptr(b_rd_nxt),
        .upd_hd_ptr(b_upd), .make_ll_empty(b_mk), .new_hd_ptr(b_new_hd),
        .free_ptr_vld(b_free_vld), .free_ptr(b_free_ptr),
        .pop_cnt(b_cnt)
    );

    logic [7:0] node_data [16];
    logic [3:0] node_nxt  [16];

    // Memory A: data valid one cycle after the strobe; zeros otherwise.
    always @(posedge clk) begin
        if (a_rd_en) begin
            a_rd_data <= node_data[a_rd_addr];
            a_rd_nxt  <= node_nxt[a_rd_addr];
        end else begin
            a_rd_data <= 8'h00;
            a_rd_nxt  <= 4'h0;
        end
    end

    // Memory B: three-stage pipeline, data valid three cycles after the strobe.
    logic [7:0] b_pd [3];
    logic [3:0] b_pn [3];
    always @(posedge clk) begin
        b_pd[0] <= b_rd_en ? node_data[b_rd_addr] : 8'h00;
        b_pn[0] <= b_rd_en ? node_nxt[b_rd_addr]  : 4'h0;
        b_pd[1] <= b_pd[0];
        b_pn[1] <= b_pn[0];
        b_pd[2] <= b_pd[1];
        b_pn[2] <= b_pn[1];
    end
    assign b_rd_data = b_pd[2];
    assign b_rd_nxt  = b_pn[2];

    int n_rd_a = 0, n_upd_a = 0, n_mk_a = 0, n_free_a = 0;
    int n_upd_b = 0, n_mk_b = 0, n_free_b = 0;
    always @(posedge clk) begin
        if (a_rd_en)    n_rd_a   <= n_rd_a + 1;
        if (a_upd)      n_upd_a  <= n_upd_a + 1;
        if (a_mk)       n_mk_a   <= n_mk_a + 1;
        if (a_free_vld) n_free_a <= n_free_a + 1;
        if (b_upd)      n_upd_b  <= n_upd_b + 1;
        if (b_mk)       n_mk_b   <= n_mk_b + 1;
        if (b_free_vld) n_free_b <= n_free_b + 1;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0]  hd;
        logic [7:0]  nd;
        logic [3:0]  nn;
        logic        exp_empty;
        logic [7:0]  exp_data;
        logic        exp_upd;
        logic        exp_mk;
        logic [3:0]  exp_new;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vec [6];

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int s_rd, s_upd, s_mk, s_free;

        //           hd     data   nxt    empty data   upd   mk    new    cnt
        vec[0] = '{4'hF, 8'h00, 4'hF, 1'b1, 8'h00, 1'b0, 1'b0, 4'hF, 16'd0};
        vec[1] = '{4'h3, 8'hA5, 4'h7, 1'b0, 8'hA5, 1'b1, 1'b0, 4'h7, 16'd1};
        vec[2] = '{4'h7, 8'h3C, 4'hF, 1'b0, 8'h3C, 1'b0, 1'b1, 4'hF, 16'd2};
        vec[3] = '{4'hF, 8'h00, 4'hF, 1'b1, 8'h00, 1'b0, 1'b0, 4'hF, 16'd2};
        vec[4] = '{4'h5, 8'h5A, 4'h5, 1'b0, 8'h5A, 1'b1, 1'b0, 4'h5, 16'd3};
        vec[5] = '{4'h0, 8'hFF, 4'hE, 1'b0, 8'hFF, 1'b1, 1'b0, 4'hE, 16'd4};

        for (int i = 0; i < 16; i++) begin
            node_data[i] = 8'h00;
            node_nxt[i]  = 4'h0;
        end

        rst = 1'b1;
        a_req_vld = 1'b1; a_rsp_rdy = 1'b1; a_cur_hd = 4'h3;
        b_req_vld = 1'b1; b_rsp_rdy = 1'b1; b_cur_hd = 4'h3;

        // Reset held with requests pending.
        repeat (3) begin
            @(negedge clk);
            chk("rst_a_rdy", a_req_rdy, 0);
            chk("rst_a_rd_en", a_rd_en, 0);
            chk("rst_a_cnt", a_cnt, 0);
            chk("rst_a_rsp_vld", a_rsp_vld, 0);
            chk("rst_a_addr", a_rd_addr, 4'hF);
            chk("rst_a_new_hd", a_new_hd, 4'hF);
            chk("rst_a_free_ptr", a_free_ptr, 4'hF);
            chk("rst_b_rdy", b_req_rdy, 0);
            chk("rst_b_rd_en", b_rd_en, 0);
        end
        rst = 1'b0;
        a_req_vld = 1'b0;
        b_req_vld = 1'b0;
        @(negedge clk);
        chk("rel_a_rdy", a_req_rdy, 1);
        chk("rel_b_rdy", b_req_rdy, 1);

        // Table-driven single pops on instance A (latency 1, response taken at once).
        for (int i = 0; i < 6; i++) begin
            node_data[vec[i].hd] = vec[i].nd;
            node_nxt[vec[i].hd]  = vec[i].nn;
            k = 0;
            while (!a_req_rdy && k < 20) begin @(negedge clk); k++; end
            chk("vec_rdy_wait", a_req_rdy, 1);
            s_rd = n_rd_a; s_upd = n_upd_a; s_mk = n_mk_a; s_free = n_free_a;
            a_cur_hd  = vec[i].hd;
            a_req_vld = 1'b1;
            @(negedge clk);                       // T+1
            a_req_vld = 1'b0;
            a_cur_hd  = 4'h1;                     // must be ignored after accept
            if (vec[i].exp_empty) begin
                chk("vec_empty_rsp_vld", a_rsp_vld, 1);
                chk("vec_empty_flag", a_rsp_empty, 1);
                chk("vec_empty_data", a_rsp_data, 0);
                chk("vec_empty_rd_en", a_rd_en, 0);
                @(negedge clk);                   // T+2
                chk("vec_empty_idle_rdy", a_req_rdy, 1);
                chk("vec_empty_rsp_drop", a_rsp_vld, 0);
                chk("vec_empty_no_rd", n_rd_a - s_rd, 0);
                chk("vec_empty_no_upd", n_upd_a - s_upd, 0);
                chk("vec_empty_no_mk", n_mk_a - s_mk, 0);
                chk("vec_empty_no_free", n_free_a - s_free, 0);
                chk("vec_empty_cnt", a_cnt, vec[i].exp_cnt);
            end else begin
                chk("vec_rd_en", a_rd_en, 1);
                chk("vec_rd_addr", a_rd_addr, vec[i].hd);
                @(negedge clk);                   // T+2 WAIT
                chk("vec_wait_rd_en", a_rd_en, 0);
                chk("vec_wait_upd", a_upd | a_mk, 0);
                @(negedge clk);                   // T+3 UPD
                chk("vec_upd", a_upd, vec[i].exp_upd);
                chk("vec_mk_empty", a_mk, vec[i].exp_mk);
                chk("vec_new_hd", a_new_hd, vec[i].exp_new);
                chk("vec_free_vld", a_free_vld, 1);
                chk("vec_free_ptr", a_free_ptr, vec[i].hd);
                @(negedge clk);                   // T+4 RESP
                chk("vec_rsp_vld", a_rsp_vld, 1);
                chk("vec_rsp_data", a_rsp_data, vec[i].exp_data);
                chk("vec_rsp_empty", a_rsp_empty, 0);
                chk("vec_resp_pulses", {a_upd, a_mk, a_free_vld}, 0);
                chk("vec_cnt", a_cnt, vec[i].exp_cnt);
                @(negedge clk);                   // T+5 IDLE
                chk("vec_idle_rdy", a_req_rdy, 1);
                chk("vec_idle_rsp", a_rsp_vld, 0);
                chk("vec_n_rd", n_rd_a - s_rd, 1);
                chk("vec_n_upd", n_upd_a - s_upd, 32'(vec[i].exp_upd));
                chk("vec_n_mk", n_mk_a - s_mk, 32'(vec[i].exp_mk));
                chk("vec_n_free", n_free_a - s_free, 1);
            end
        end

        // Backpressure with 3-cycle memory latency on instance B.
        node_data[9] = 8'hC3;
        node_nxt[9]  = 4'h2;
        s_upd = n_upd_b;
        b_rsp_rdy = 1'b0;
        b_cur_hd  = 4'h9;
        b_req_vld = 1'b1;
        @(negedge clk);                           // T+1
        b_req_vld = 1'b0;
        b_cur_hd  = 4'hF;
        chk("bp_rd_en", b_rd_en, 1);
        chk("bp_rd_addr", b_rd_addr, 4'h9);
        repeat (3) begin                          // T+2..T+4
            @(negedge clk);
            chk("bp_wait_no_upd", b_upd | b_mk | b_free_vld, 0);
            chk("bp_wait_rdy", b_req_rdy, 0);
        end
        @(negedge clk);                           // T+5
        chk("bp_upd", b_upd, 1);
        chk("bp_mk", b_mk, 0);
        chk("bp_new_hd", b_new_hd, 4'h2);
        chk("bp_free_vld", b_free_vld, 1);
        chk("bp_free_ptr", b_free_ptr, 4'h9);
        repeat (5) begin                          // T+6..T+10, rsp_rdy low
            @(negedge clk);
            chk("bp_hold_vld", b_rsp_vld, 1);
            chk("bp_hold_data", b_rsp_data, 8'hC3);
            chk("bp_hold_rdy", b_req_rdy, 0);
        end
        @(negedge clk);                           // T+11, handshake
        b_rsp_rdy = 1'b1;
        chk("bp_hs_vld", b_rsp_vld, 1);
        chk("bp_hs_data", b_rsp_data, 8'hC3);
        @(negedge clk);                           // T+12
        chk("bp_idle_rdy", b_req_rdy, 1);
        chk("bp_idle_rsp", b_rsp_vld, 0);
        chk("bp_upd_once", n_upd_b - s_upd, 1);
        chk("bp_cnt", b_cnt, 1);

        // Reset in the middle of WAIT on instance B.
        node_data[4] = 8'h11;
        node_nxt[4]  = 4'h6;
        s_upd = n_upd_b; s_mk = n_mk_b; s_free = n_free_b;
        b_cur_hd  = 4'h4;
        b_req_vld = 1'b1;
        @(negedge clk);                           // T+1 RD
        b_req_vld = 1'b0;
        chk("mr_rd_en", b_rd_en, 1);
        @(negedge clk);                           // T+2 WAIT
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_rsp_vld", b_rsp_vld, 0);
        chk("mr_rdy_in_rst", b_req_rdy, 0);
        chk("mr_cnt_b", b_cnt, 0);
        chk("mr_cnt_a", a_cnt, 0);
        repeat (6) @(negedge clk);
        chk("mr_idle_rdy", b_req_rdy, 1);
        chk("mr_no_rsp", b_rsp_vld, 0);
        chk("mr_no_upd", (n_upd_b - s_upd) + (n_mk_b - s_mk), 0);
        chk("mr_no_free", n_free_b - s_free, 0);

        b_cur_hd  = 4'h4;
        b_req_vld = 1'b1;
        @(negedge clk);                           // T+1
        b_req_vld = 1'b0;
        chk("mr2_rd_en", b_rd_en, 1);
        repeat (3) @(negedge clk);                // T+2..T+4
        @(negedge clk);                           // T+5
        chk("mr2_upd", b_upd, 1);
        chk("mr2_new_hd", b_new_hd, 4'h6);
        chk("mr2_free_ptr", b_free_ptr, 4'h4);
        @(negedge clk);                           // T+6
        chk("mr2_rsp_vld", b_rsp_vld, 1);
        chk("mr2_rsp_data", b_rsp_data, 8'h11);
        chk("mr2_cnt", b_cnt, 1);
        @(negedge clk);                           // T+7
        chk("mr2_idle_rdy", b_req_rdy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ll_head_pop.md
Name: ll_head_pop

Overview:
- Pop engine that consumes the current head pointer of the linked list.
- Reads the head node (data plus next pointer) from node memory and returns the data to the requester.
- Drives the head-pointer update interface: upd_hd_ptr with new_hd_ptr, or make_ll_empty when the popped node was the last one.
- Returns the freed node address to the free-list manager.

Parameters:
- PTR_WD, 4, node pointer width. The all-ones value is NULL (empty list / end of list).
- DATA_WD, 8, node payload width.
- MEM_RD_LAT, 1, node-memory read latency in cycles. Legal range is 1..4.
- CNT_WD, 16, width of the successful-pop counter.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  synchronous reset, active-high.
- pop_req_vld  in  1  pop request.
- pop_req_rdy  out  1  engine can accept a request.
- pop_rsp_vld  out  1  response valid.
- pop_rsp_rdy  in  1  requester accepts the response.
- pop_rsp_data  out  DATA_WD  popped payload.
- pop_rsp_empty  out  1  request hit an empty list; pop_rsp_data=0.
- cur_hd_ptr  in  PTR_WD  current head pointer.
- mem_rd_en  out  1  node-memory read strobe.
- mem_rd_addr  out  PTR_WD  node address.
- mem_rd_data  in  DATA_WD  node payload, valid MEM_RD_LAT cycles after mem_rd_en.
- mem_rd_nxt_ptr  in  PTR_WD  node next pointer, same timing as mem_rd_data.
- upd_hd_ptr  out  1  one-cycle head-update pulse.
- make_ll_empty  out  1  one-cycle list-empty pulse.
- new_hd_ptr  out  PTR_WD  new head value.
- free_ptr_vld  out  1  one-cycle pulse returning a node to the free list.
- free_ptr  out  PTR_WD  freed node address.
- pop_cnt  out  CNT_WD  count of successful (non-empty) pops.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high on port reset_n.
- While reset_n=1:
  - state=IDLE.
  - All outputs 0, except mem_rd_addr, new_hd_ptr and free_ptr, which are all-ones (NULL).
  - pop_req_rdy=0 and pop_cnt=0.
- Reset has priority over everything. Reset mid-operation aborts the operation with no update/free pulse; a pending response is dropped.
- FSM states: IDLE, RD, WAIT, UPD, RESP. pop_req_rdy=1 only in IDLE, and only when reset_n=0.
- IDLE:
  - A request is accepted on pop_req_vld&pop_req_rdy at cycle T. cur_hd_ptr is latched into hd_q at T.
  - If cur_hd_ptr==NULL: go to RESP with empty_q=1. No memory read, no update, no free. Response is visible at T+1.
  - Otherwise: go to RD.
- RD (T+1): mem_rd_en=1 and mem_rd_addr=hd_q for exactly one cycle. Then go to WAIT.
- WAIT:
  - A down-counter loaded with MEM_RD_LAT-1 runs here; the FSM stays in WAIT for MEM_RD_LAT cycles.
  - mem_rd_data and mem_rd_nxt_ptr are captured in the final WAIT cycle (cycle T+1+MEM_RD_LAT).
  - Then go to UPD.
- UPD, one cycle:
  - If the captured nxt==NULL: make_ll_empty=1, upd_hd_ptr=0, new_hd_ptr=NULL.
  - Else: upd_hd_ptr=1, make_ll_empty=0, new_hd_ptr=nxt.
  - Never assert both update pulses.
  - free_ptr_vld=1 with free_ptr=hd_q.
  - pop_cnt increments by 1, wrapping modulo 2^CNT_WD.
  - Then go to RESP.
- RESP:
  - pop_rsp_vld=1; pop_rsp_data and pop_rsp_empty are held stable until pop_rsp_rdy.
  - On pop_rsp_vld&pop_rsp_rdy, go to IDLE in the next cycle.
  - Back-to-back requests: earliest next accept is the cycle after the handshake.
- Latency for a non-empty pop with pop_rsp_rdy tied high: accept T, UPD at T+2+MEM_RD_LAT, pop_rsp_vld at T+3+MEM_RD_LAT, engine in IDLE at T+4+MEM_RD_LAT.
- Head-pointer sampling:
  - cur_hd_ptr is sampled only at accept.
  - Changes to cur_hd_ptr during RD/WAIT are ignored; ownership of the head by the pop path is the requester's responsibility.
  - The head register updates on the edge ending UPD, so cur_hd_ptr shows the new value from the first RESP cycle.
- Outside their state, mem_rd_en, upd_hd_ptr, make_ll_empty and free_ptr_vld are 0. new_hd_ptr, free_ptr and mem_rd_addr hold their last value.
- Self-loop (nxt==hd_q) is treated as a normal non-NULL next pointer. No detection is performed.

Test Plan:
- Reset: hold reset_n=1 for 3 cycles with pop_req_vld=1 -> pop_req_rdy=0, no mem_rd_en, pop_cnt=0. On release, pop_req_rdy=1 the next cycle.
- Empty pop: cur_hd_ptr=4'hF, accept at T -> pop_rsp_vld=1, pop_rsp_empty=1, pop_rsp_data=0 at T+1. No mem_rd_en, upd_hd_ptr, make_ll_empty or free_ptr_vld. pop_cnt stays 0.
- Middle pop, MEM_RD_LAT=1: cur_hd_ptr=3, node3={data=8'hA5, nxt=7} ->
  - mem_rd_en with addr 3 at T+1.
  - At T+3: upd_hd_ptr=1, new_hd_ptr=7, free_ptr=3.
  - At T+4: pop_rsp_vld=1 with pop_rsp_data=A5.
  - pop_cnt=1.
- Last-node pop: cur_hd_ptr=7, node7={8'h3C, NULL} -> make_ll_empty=1, upd_hd_ptr=0, free_ptr=7, pop_rsp_data=3C. A following pop returns empty.
- Backpressure and latency: MEM_RD_LAT=3, pop_rsp_rdy=0 for 5 cycles -> pop_rsp_vld is held with stable data, pop_req_rdy=0 throughout, the update pulse occurs once at T+5, and IDLE is reached one cycle after the handshake.
- Reset mid-WAIT: assert reset_n during WAIT -> no update/free pulse, no response, state IDLE, and a new pop after release proceeds normally.
